// File: rtl/pipe_ctrl.sv
// pipe_ctrl: five-stage pipeline sequencer (stalls, flushes, PC select, exception/interrupt entry).
// Optional build macro PIPE_CTRL_PERF_EN adds stall/flush event counters.
`default_nettype none

module pipe_ctrl #(
  parameter int         DRAIN_CYCLES = 3,
  parameter logic [3:0] IRQ_CAUSE    = 4'hF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hazard_stall_i,
  input  logic        mem_busy_i,
  input  logic        exe_busy_i,
  input  logic        branch_taken_i,
  input  logic        exc_req_i,
  input  logic [3:0]  exc_cause_i,
  input  logic        int_req_i,
  input  logic        int_en_i,
  input  logic        halt_i,
  output logic        if_en_o,
  output logic        id_en_o,
  output logic        exe_en_o,
  output logic        mem_en_o,
  output logic        wb_en_o,
  output logic        id_flush_o,
  output logic        exe_flush_o,
  output logic        mem_bubble_o,
  output logic [1:0]  pc_sel_o,
  output logic [3:0]  vec_o,
  output logic        exc_ack_o,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
`endif
  output logic        halted_o
);

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_VECTOR = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [3:0] vec_nxt;
  logic       irq;

  assign irq = int_req_i & int_en_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= S_RUN;
      cnt   <= 4'd0;
      vec_o <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      vec_o <= vec_nxt;
    end
  end

  always_comb begin
    if_en_o      = 1'b0;
    id_en_o      = 1'b0;
    exe_en_o     = 1'b0;
    mem_en_o     = 1'b0;
    wb_en_o      = 1'b0;
    id_flush_o   = 1'b0;
    exe_flush_o  = 1'b0;
    mem_bubble_o = 1'b0;
    pc_sel_o     = 2'd0;
    exc_ack_o    = 1'b0;
    halted_o     = 1'b0;
    state_nxt    = state;
    cnt_nxt      = cnt;
    vec_nxt      = vec_o;

    case (state)
      S_RUN: begin
        if (mem_busy_i) begin
          // full freeze; any pending event is re-sampled next cycle
        end else if (exc_req_i || irq || halt_i) begin
          id_en_o     = 1'b1;
          exe_en_o    = 1'b1;
          mem_en_o    = 1'b1;
          wb_en_o     = 1'b1;
          id_flush_o  = 1'b1;
          exe_flush_o = 1'b1;
          if (exc_req_i || irq) begin
            vec_nxt   = exc_req_i ? exc_cause_i : IRQ_CAUSE;
            cnt_nxt   = DRAIN_INIT;
            state_nxt = S_DRAIN;
          end else begin
            state_nxt = S_HALT;
          end
        end else if (exe_busy_i) begin
          mem_en_o     = 1'b1;
          wb_en_o      = 1'b1;
          mem_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
          if_en_o     = 1'b1;
          id_en_o     = 1'b1;
          exe_en_o    = 1'b1;
          mem_en_o    = 1'b1;
          wb_en_o     = 1'b1;
          id_flush_o  = 1'b1;
          exe_flush_o = 1'b1;
          pc_sel_o    = 2'd1;
        end else if (hazard_stall_i) begin
          exe_en_o    = 1'b1;
          mem_en_o    = 1'b1;
          wb_en_o     = 1'b1;
          exe_flush_o = 1'b1;
        end else begin
          if_en_o  = 1'b1;
          id_en_o  = 1'b1;
          exe_en_o = 1'b1;
          mem_en_o = 1'b1;
          wb_en_o  = 1'b1;
        end
      end

      S_DRAIN: begin
        if (!mem_busy_i) begin
          id_en_o     = 1'b1;
          exe_en_o    = 1'b1;
          mem_en_o    = 1'b1;
          wb_en_o     = 1'b1;
          id_flush_o  = 1'b1;
          exe_flush_o = 1'b1;
          cnt_nxt     = cnt - 4'd1;
          if (cnt <= 4'd1) begin
            cnt_nxt   = 4'd0;
            state_nxt = S_VECTOR;
          end
        end
      end

      S_VECTOR: begin
        pc_sel_o = 2'd2;
        if (!mem_busy_i) begin
          if_en_o     = 1'b1;
          id_en_o     = 1'b1;
          exe_en_o    = 1'b1;
          mem_en_o    = 1'b1;
          wb_en_o     = 1'b1;
          id_flush_o  = 1'b1;
          exe_flush_o = 1'b1;
          exc_ack_o   = 1'b1;
          state_nxt   = S_RUN;
        end
      end

      S_HALT: begin
        halted_o = 1'b1;
        if (irq) begin
          vec_nxt   = IRQ_CAUSE;
          cnt_nxt   = DRAIN_INIT;
          state_nxt = S_DRAIN;
        end
      end

      default: state_nxt = S_RUN;
    endcase

    // Outputs are forced quiet for as long as reset is held.
    if (!rst_i) begin
      if_en_o      = 1'b0;
      id_en_o      = 1'b0;
      exe_en_o     = 1'b0;
      mem_en_o     = 1'b0;
      wb_en_o      = 1'b0;
      id_flush_o   = 1'b0;
      exe_flush_o  = 1'b0;
      mem_bubble_o = 1'b0;
      pc_sel_o     = 2'd0;
      exc_ack_o    = 1'b0;
      halted_o     = 1'b0;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic stall_evt, flush_evt;

  // Event entries into DRAIN/HALT also drop if_en_o but are not counted as stalls.
  assign stall_evt = (state == S_RUN) && !if_en_o && (state_nxt == S_RUN);
  assign flush_evt = ((state == S_RUN) && (pc_sel_o == 2'd1)) ||
                     ((state != S_DRAIN) && (state_nxt == S_DRAIN));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= 32'd0;
      flush_cnt_o <= 32'd0;
    end else begin
      if (stall_evt) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (flush_evt) flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire
